// File: rtl/mem_arb_pkg.sv
// Shared encodings for the single-port memory arbiter: FSM states, owner ids, wait counter width.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam int LAT_CNT_W = 4;
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Two-way request picker: fixed priority (data first) by default, round-robin when ARB_RR_EN is defined.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef ARB_RR_EN
  input  owner_e     last_grant,
`endif
  output logic [1:0] gnt
);
  logic prefer_data;

`ifdef ARB_RR_EN
  assign prefer_data = (last_grant == OWN_INST);
`else
  assign prefer_data = 1'b1;
`endif

  // bit 0 = instruction side, bit 1 = data side
  always_comb begin
    gnt = '0;
    if (req == 2'b11) gnt = prefer_data ? 2'b10 : 2'b01;
    else              gnt = req;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM requesters onto one synchronous SRAM, one transaction at a time.
// Define ARB_RR_EN for round-robin on conflicts; otherwise data always beats fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [LAT_CNT_W-1:0] LAT_C = LAT_CNT_W'(MEM_LAT);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end
  endgenerate

  state_e               state;
  owner_e               owner_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 we_q;
  logic [STRB_W-1:0]    wstrb_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [LAT_CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0]    inst_rdata_q;
  logic [DATA_W-1:0]    data_rdata_q;
  logic [1:0]           pick;
  logic                 idle;
  logic                 issue;

`ifdef ARB_RR_EN
  owner_e last_grant_q;
`endif

  arb_pick u_pick (
    .req        ({data_req, inst_req}),
`ifdef ARB_RR_EN
    .last_grant (last_grant_q),
`endif
    .gnt        (pick)
  );

  assign idle  = (state == ST_IDLE);
  assign issue = (state == ST_ISSUE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      owner_q      <= OWN_INST;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= OWN_INST;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pick) begin
            state <= ST_ISSUE;
            if (pick[1]) begin
              owner_q <= OWN_DATA;
              addr_q  <= data_addr;
              we_q    <= data_we;
              wstrb_q <= data_wstrb;
              wdata_q <= data_wdata;
            end else begin
              owner_q <= OWN_INST;
              addr_q  <= inst_addr;
              we_q    <= 1'b0;
              wstrb_q <= '0;
              wdata_q <= '0;
            end
`ifdef ARB_RR_EN
            last_grant_q <= pick[1] ? OWN_DATA : OWN_INST;
`endif
          end
        end
        ST_ISSUE: begin
          cnt_q <= LAT_CNT_W'(1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // read data is only valid on the exact MEM_LAT-th cycle after mem_en
          if (cnt_q == LAT_C) begin
            if (owner_q == OWN_DATA) data_rdata_q <= we_q ? '0 : mem_rdata;
            else                     inst_rdata_q <= mem_rdata;
            state <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + LAT_CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign inst_gnt    = idle & pick[0];
  assign data_gnt    = idle & pick[1];
  assign inst_rvalid = (state == ST_RESP) && (owner_q == OWN_INST);
  assign data_rvalid = (state == ST_RESP) && (owner_q == OWN_DATA);
  assign inst_rdata  = inst_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign mem_en      = issue;
  assign mem_we      = (issue && we_q) ? wstrb_q : '0;
  assign mem_addr    = issue ? addr_q : '0;
  assign mem_wdata   = issue ? wdata_q : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_req3, data_we;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_wstrb;

  logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid, mem_en;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;

  logic        inst_gnt3, inst_rvalid3, data_gnt3, data_rvalid3, mem_en3;
  logic [31:0] inst_rdata3, data_rdata3, mem_addr3, mem_wdata3;
  logic [3:0]  mem_we3;

  int n_checks = 0;
  int n_errors = 0;
  bit lg_data  = 1'b0;
  bit w;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn),
    .inst_req(1'b0), .inst_addr(inst_addr), .inst_gnt(inst_gnt3),
    .inst_rvalid(inst_rvalid3), .inst_rdata(inst_rdata3),
    .data_req(data_req3), .data_we(data_we), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt3),
    .data_rvalid(data_rvalid3), .data_rdata(data_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected winner from the arbitration rule and the bench's own last-grant record.
  function automatic bit pick_data(input bit ir, input bit dr);
    if (ir && dr) return RR ? !lg_data : 1'b1;
    return dr;
  endfunction

  // Called in grant cycle T (inputs driven and settled); returns settled in cycle T+4.
  task automatic serve(input bit exp_data, input bit drop, input logic [31:0] rd,
                       input logic [31:0] e_addr, input logic [3:0] e_we,
                       input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    chk("gnt_inst", inst_gnt, !exp_data);
    chk("gnt_data", data_gnt, exp_data);
    lg_data = exp_data;
    next_cyc();
    if (drop) begin
      if (exp_data) data_req = 1'b0;
      else          inst_req = 1'b0;
    end
    #2;
    chk("issue_en", mem_en, 1'b1);
    chk("issue_addr", mem_addr, e_addr);
    chk("issue_we", mem_we, e_we);
    chk("issue_wdata", mem_wdata, e_wdata);
    next_cyc();
    mem_rdata = rd;
    #2;
    chk("wait_en", mem_en, 1'b0);
    chk("wait_addr", mem_addr, 32'h0);
    chk("wait_gnt", {inst_gnt, data_gnt}, 2'b00);
    next_cyc();
    mem_rdata = 32'hBAD0BAD0;
    #2;
    chk("resp_ivalid", inst_rvalid, !exp_data);
    chk("resp_dvalid", data_rvalid, exp_data);
    chk("resp_rdata", exp_data ? data_rdata : inst_rdata, e_rdata);
    next_cyc();
    #2;
    chk("post_valid", {inst_rvalid, data_rvalid}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; inst_req = 0; data_req = 0; data_req3 = 0; data_we = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0; mem_rdata = 0;
    repeat (3) next_cyc();
    #2;
    chk("rst_en", mem_en, 1'b0);
    chk("rst_gnt", {inst_gnt, data_gnt}, 2'b00);
    chk("rst_valid", {inst_rvalid, data_rvalid}, 2'b00);
    chk("rst_rdata", inst_rdata | data_rdata, 32'h0);
    next_cyc();
    resetn = 1'b1;
    #2;
    chk("idle_en", mem_en, 1'b0);

    // fetch only
    next_cyc();
    inst_req = 1'b1; inst_addr = 32'h1C000000;
    #2;
    serve(1'b0, 1'b1, 32'h02800421, 32'h1C000000, 4'h0, 32'h0, 32'h02800421);

    // store
    next_cyc();
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h100;
    data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF;
    #2;
    serve(1'b1, 1'b1, 32'h11112222, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0);
    chk("inst_rdata_hold", inst_rdata, 32'h02800421);

    // conflict, winner drops after its grant, loser follows at T+4
    for (int r = 0; r < 2; r++) begin
      next_cyc();
      inst_req = 1'b1; data_req = 1'b1; data_we = 1'b0; data_wstrb = 4'h0;
      inst_addr = 32'h1C000004 + 32'(r * 8); data_addr = 32'h104;
      w = pick_data(1'b1, 1'b1);
      #2;
      serve(w, 1'b1, 32'hA0000000 + 32'(r), w ? 32'h104 : inst_addr, 4'h0,
            w ? 32'hDEADBEEF : 32'h0, 32'hA0000000 + 32'(r));
      serve(!w, 1'b1, 32'hB0000000 + 32'(r), !w ? 32'h104 : inst_addr, 4'h0,
            !w ? 32'hDEADBEEF : 32'h0, 32'hB0000000 + 32'(r));
    end

    // both held continuously
    next_cyc();
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h1C000040; data_addr = 32'h200;
    #2;
    for (int k = 0; k < 4; k++) begin
      w = pick_data(1'b1, 1'b1);
      serve(w, 1'b0, 32'hC0000000 + 32'(k), w ? 32'h200 : 32'h1C000040, 4'h0,
            w ? 32'hDEADBEEF : 32'h0, 32'hC0000000 + 32'(k));
    end
    inst_req = 1'b0; data_req = 1'b0;
    next_cyc();
    #2;
    chk("held_drop_en", mem_en, 1'b0);

    // MEM_LAT=3 load
    data_req3 = 1'b1; data_we = 1'b0; data_addr = 32'h300; data_wdata = 32'h0;
    #2;
    chk("lat3_gnt", data_gnt3, 1'b1);
    next_cyc();
    data_req3 = 1'b0;
    #2;
    chk("lat3_en", mem_en3, 1'b1);
    chk("lat3_addr", mem_addr3, 32'h300);
    for (int c = 0; c < 2; c++) begin
      next_cyc();
      mem_rdata = 32'hEEEE0000 + 32'(c);
      #2;
      chk("lat3_early_valid", data_rvalid3, 1'b0);
    end
    next_cyc();
    mem_rdata = 32'h5A5A1234;
    #2;
    chk("lat3_t4_en", mem_en3, 1'b0);
    next_cyc();
    mem_rdata = 32'hEEEEFFFF;
    #2;
    chk("lat3_valid", data_rvalid3, 1'b1);
    chk("lat3_rdata", data_rdata3, 32'h5A5A1234);
    next_cyc();
    #2;
    chk("lat3_post", data_rvalid3, 1'b0);

    // reset mid-transaction
    next_cyc();
    inst_req = 1'b1; inst_addr = 32'h1C000080;
    #2;
    chk("mrst_gnt", inst_gnt, 1'b1);
    next_cyc();
    inst_req = 1'b0; data_req3 = 1'b1; data_addr = 32'h3000;
    #2;
    chk("mrst_gnt3", data_gnt3, 1'b1);
    next_cyc();
    data_req3 = 1'b0;
    #2;
    chk("mrst_pre_en3", mem_en3, 1'b1);
    resetn = 1'b0;
    #1;
    chk("mrst_en3", mem_en3, 1'b0);
    chk("mrst_addr3", mem_addr3, 32'h0);
    chk("mrst_rdata3", data_rdata3, 32'h0);
    chk("mrst_irdata", inst_rdata, 32'h0);
    chk("mrst_drdata", data_rdata, 32'h0);
    for (int c = 0; c < 2; c++) begin
      next_cyc();
      #2;
      chk("mrst_valid", {inst_rvalid, data_rvalid, data_rvalid3}, 3'b000);
      chk("mrst_en", mem_en | mem_en3, 1'b0);
    end
    next_cyc();
    resetn = 1'b1; lg_data = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C0000C0;
    #2;
    serve(1'b0, 1'b1, 32'h12345678, 32'h1C0000C0, 4'h0, 32'h0, 32'h12345678);

    // first conflict after reset
    next_cyc();
    inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h400; inst_addr = 32'h1C000100;
    w = pick_data(1'b1, 1'b1);
    #2;
    serve(w, 1'b1, 32'h0F0F0F0F, w ? 32'h400 : 32'h1C000100, 4'h0, 32'h0, 32'h0F0F0F0F);
    serve(!w, 1'b1, 32'hF0F0F0F0, !w ? 32'h400 : 32'h1C000100, 4'h0, 32'h0, 32'hF0F0F0F0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
